// File: rtl/param_datapath_if.sv
// Control/data bundle between the decode unit, the datapath and the memory interface.
interface param_datapath_if #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 4
);
  logic [2:0]          alu_op;
  logic                form;
  logic [REG_ADDR-1:0] A;
  logic [REG_ADDR-1:0] B;
  logic [REG_ADDR-1:0] C;
  logic [REG_ADDR-1:0] D;
  logic [REG_ADDR-1:0] Y1;
  logic [REG_ADDR-1:0] Y2;
  logic [1:0]          write;
  logic                const_c;
  logic [WIDTH-1:0]    constant;
  logic                ld;
  logic [WIDTH-1:0]    ld_data;
  logic                pc_inc;
  logic [2:0]          compare_op;
  logic [WIDTH-1:0]    st_data;
  logic [WIDTH-1:0]    program_counter;
  logic                condition;
  logic                busy;
  logic                div0;

  modport master (
    output alu_op, form, A, B, C, D, Y1, Y2, write, const_c, constant,
           ld, ld_data, pc_inc, compare_op,
    input  st_data, program_counter, condition, busy, div0
  );

  modport slave (
    input  alu_op, form, A, B, C, D, Y1, Y2, write, const_c, constant,
           ld, ld_data, pc_inc, compare_op,
    output st_data, program_counter, condition, busy, div0
  );
endinterface

// File: rtl/param_datapath.sv
// Parametrised two-lane register-file datapath with a multi-cycle unsigned
// MULT/DIV unit; a busy interlock freezes the register file and the PC.
module param_datapath #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 4,
  parameter int PC_STEP  = 1
) (
  input logic             clk,
  input logic             rst,
  param_datapath_if.slave bus
);
  localparam int NREGS = 2 ** REG_ADDR;
  localparam int CW    = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_COPY = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_regs [NREGS];
  logic [WIDTH-1:0]    r_pc;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_opb;
  logic [CW-1:0]       r_cnt;
  logic [REG_ADDR-1:0] r_y1;
  logic [REG_ADDR-1:0] r_y2;
  logic [1:0]          r_wr;
  logic                r_is_div;
  logic                r_div0;
  logic                r_busy;

  logic [WIDTH-1:0]    w_a, w_b, w_c, w_d;
  logic [WIDTH-1:0]    w_opnd2, w_alu1, w_lane1, w_lane2;
  logic                w_is_mc, w_issue;
  logic [1:0]          w_wen;
  logic [REG_ADDR-1:0] w_wa1, w_wa2;
  logic [WIDTH-1:0]    w_wd1, w_wd2;
  logic [WIDTH:0]      w_mul_sum, w_div_tmp;
  logic [WIDTH-1:0]    w_div_sub;
  logic                w_div_ge;

  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_COPY: return x;
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  function automatic logic cmp_f(input logic [2:0] op,
                                 input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x == y;
      3'd1:    return x != y;
      3'd2:    return x < y;
      3'd3:    return x >= y;
      3'd4:    return $signed(x) < $signed(y);
      3'd5:    return $signed(x) >= $signed(y);
      default: return 1'b0;
    endcase
  endfunction

  // Operand fetch, single-cycle lane results and issue detection
  always_comb begin
    w_a = r_regs[bus.A];
    w_b = r_regs[bus.B];
    w_c = r_regs[bus.C];
    w_d = r_regs[bus.D];
    if (bus.form) begin
      w_opnd2 = w_b;
    end else if (bus.const_c) begin
      w_opnd2 = bus.constant;
    end else begin
      w_opnd2 = w_c;
    end
    w_alu1 = alu_f(bus.alu_op, w_a, w_opnd2);
    if (bus.form) begin
      w_lane2 = alu_f(bus.alu_op, w_c, w_d);
    end else begin
      w_lane2 = w_alu1;
    end
    if (bus.ld) begin
      w_lane1 = bus.ld_data;
    end else begin
      w_lane1 = w_alu1;
    end
    w_is_mc = (bus.alu_op == OP_MULT) || (bus.alu_op == OP_DIV);
    w_issue = (r_state == S_IDLE) && w_is_mc && (bus.write != 2'b00);
  end

  // Write-port source: multi-cycle result at WB, otherwise the single-cycle lanes
  always_comb begin
    w_wen = 2'b00;
    w_wa1 = bus.Y1;
    w_wa2 = bus.Y2;
    w_wd1 = w_lane1;
    w_wd2 = w_lane2;
    if (r_state == S_WB) begin
      w_wen = r_wr;
      w_wa1 = r_y1;
      w_wa2 = r_y2;
      w_wd1 = r_lo;
      w_wd2 = r_hi;
    end else if ((r_state == S_IDLE) && !w_is_mc) begin
      w_wen = bus.write;
    end else begin
      w_wen = 2'b00;
    end
  end

  // One shift-add / restoring-division step; hi:lo is product or remainder:quotient
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_div_tmp = {r_hi, r_lo[WIDTH-1]};
    w_div_ge  = (w_div_tmp >= {1'b0, r_opb});
    w_div_sub = w_div_tmp[WIDTH-1:0] - r_opb;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = (bus.alu_op == OP_DIV) ? S_DIV : S_MUL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Multi-cycle operand capture and iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_opb    <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_y1     <= {REG_ADDR{1'b0}};
      r_y2     <= {REG_ADDR{1'b0}};
      r_wr     <= 2'b00;
      r_is_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= w_a;
            r_opb    <= w_opnd2;
            r_cnt    <= CW'(WIDTH - 1);
            r_y1     <= bus.Y1;
            r_y2     <= bus.Y2;
            r_wr     <= bus.write;
            r_is_div <= (bus.alu_op == OP_DIV);
          end
        end
        S_MUL: begin
          r_hi  <= w_mul_sum[WIDTH:1];
          r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_hi  <= w_div_ge ? w_div_sub : w_div_tmp[WIDTH-1:0];
          r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Sticky divide-by-zero flag, cleared by the next DIV issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div0 <= 1'b0;
    end else if (w_issue && (bus.alu_op == OP_DIV)) begin
      r_div0 <= 1'b0;
    end else if ((r_state == S_WB) && r_is_div) begin
      r_div0 <= (r_opb == {WIDTH{1'b0}});
    end
  end

  // Register file; lane 1 is written last so it wins a Y1==Y2 collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_wen[1]) r_regs[w_wa2] <= w_wd2;
      if (w_wen[0]) r_regs[w_wa1] <= w_wd1;
    end
  end

  // Program counter, frozen while a multi-cycle op is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= {WIDTH{1'b0}};
    end else if (bus.pc_inc && (r_state == S_IDLE)) begin
      r_pc <= r_pc + WIDTH'(PC_STEP);
    end
  end

  assign bus.st_data         = w_d;
  assign bus.condition       = cmp_f(bus.compare_op, w_a, w_b);
  assign bus.program_counter = r_pc;
  assign bus.busy            = r_busy;
  assign bus.div0            = r_div0;
endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized instructions against a plain-arithmetic register-file model.
module tb_param_datapath;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b100, OP_MUL = 3'b001, OP_DIV = 3'b101;
  localparam logic [2:0] OP_AND = 3'b010, OP_OR = 3'b011, OP_XOR = 3'b110, OP_CPY = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic        form;
    logic [3:0]  a, b, c, d, y1, y2;
    logic [1:0]  wr;
    logic        cc;
    logic [31:0] k;
    logic        ld;
    logic [31:0] ldd;
    logic        pcinc;
  } instr_t;

  typedef struct packed {
    instr_t      in;
    logic [3:0]  r1;
    logic [31:0] e1;
    logic [3:0]  r2;
    logic [31:0] e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_datapath_if #(.WIDTH(32), .REG_ADDR(4)) bus ();
  param_datapath_if #(.WIDTH(8),  .REG_ADDR(2)) sbus ();

  param_datapath #(.WIDTH(32), .REG_ADDR(4), .PC_STEP(1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  param_datapath #(.WIDTH(8),  .REG_ADDR(2), .PC_STEP(1)) u_small (.clk(clk), .rst(rst), .bus(sbus));

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] m_reg [16];
  logic [31:0] m_pc;
  logic        m_div0;
  vec_t        vt [12];

  function automatic instr_t mk(input logic [2:0] op, input logic form,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d,
                                input logic [3:0] y1, input logic [3:0] y2,
                                input logic [1:0] wr, input logic cc, input logic [31:0] k,
                                input logic ld, input logic [31:0] ldd, input logic pcinc);
    instr_t t;
    t.op = op; t.form = form; t.a = a; t.b = b; t.c = c; t.d = d;
    t.y1 = y1; t.y2 = y2; t.wr = wr; t.cc = cc; t.k = k;
    t.ld = ld; t.ldd = ldd; t.pcinc = pcinc;
    return t;
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return x;
    endcase
  endfunction

  function automatic logic m_cond(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (op)
      3'd0:    return x == y;
      3'd1:    return x != y;
      3'd2:    return x < y;
      3'd3:    return x >= y;
      3'd4:    return sx < sy;
      3'd5:    return sx >= sy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_op = OP_ADD; bus.form = 1'b0; bus.A = 4'd0; bus.B = 4'd0; bus.C = 4'd0;
    bus.D = 4'd0; bus.Y1 = 4'd0; bus.Y2 = 4'd0; bus.write = 2'b00; bus.const_c = 1'b0;
    bus.constant = 32'd0; bus.ld = 1'b0; bus.ld_data = 32'd0; bus.pc_inc = 1'b0;
    bus.compare_op = 3'd0;
  endtask

  task automatic drive(input instr_t t);
    bus.alu_op = t.op; bus.form = t.form; bus.A = t.a; bus.B = t.b; bus.C = t.c;
    bus.D = t.d; bus.Y1 = t.y1; bus.Y2 = t.y2; bus.write = t.wr; bus.const_c = t.cc;
    bus.constant = t.k; bus.ld = t.ld; bus.ld_data = t.ldd; bus.pc_inc = t.pcinc;
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] v);
    bus.D = idx;
    @(negedge clk);
    v = bus.st_data;
  endtask

  task automatic cmp_chk(input string nm, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic exp);
    bus.A = a; bus.B = b; bus.compare_op = op;
    @(negedge clk);
    chk(nm, bus.condition, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
    m_pc   = 32'd0;
    m_div0 = 1'b0;
  endtask

  // Apply one instruction and advance the model; waits out multi-cycle ops.
  task automatic run(input instr_t t);
    logic [31:0] x, y, l1, l2;
    logic [63:0] p;
    logic        mc;
    int          n;
    x  = m_reg[t.a];
    y  = t.form ? m_reg[t.b] : (t.cc ? t.k : m_reg[t.c]);
    mc = ((t.op == OP_MUL) || (t.op == OP_DIV)) && (t.wr != 2'b00);
    if (t.op == OP_MUL) begin
      p  = 64'(x) * 64'(y);
      l1 = p[31:0];
      l2 = p[63:32];
    end else if (t.op == OP_DIV) begin
      l1 = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      l2 = (y == 32'd0) ? x : x % y;
    end else begin
      l1 = t.ld ? t.ldd : m_alu(t.op, x, y);
      l2 = t.form ? m_alu(t.op, m_reg[t.c], m_reg[t.d]) : m_alu(t.op, x, y);
    end
    drive(t);
    step();
    if (t.pcinc) m_pc = m_pc + 32'd1;
    if (mc) begin
      chk("busy_at_issue", bus.busy, 1);
      if (t.op == OP_DIV) begin
        m_div0 = 1'b0;
        chk("div0_clear_at_issue", bus.div0, m_div0);
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
        bus.pc_inc = 1'b1; bus.write = 2'b11; bus.alu_op = OP_ADD; bus.ld = 1'b1;
        bus.Y1 = 4'($urandom); bus.Y2 = 4'($urandom); bus.ld_data = $urandom;
        step();
        n++;
      end
      chk("busy_cycles", n, 33);
      if (t.op == OP_DIV) m_div0 = (y == 32'd0);
    end
    if (mc || !((t.op == OP_MUL) || (t.op == OP_DIV))) begin
      if (t.wr[1]) m_reg[t.y2] = l2;
      if (t.wr[0]) m_reg[t.y1] = l1;
    end
    idle();
  endtask

  function automatic instr_t rnd_instr();
    instr_t t;
    t.op = 3'($urandom_range(0, 7)); t.form = 1'($urandom);
    t.a = 4'($urandom); t.b = 4'($urandom); t.c = 4'($urandom); t.d = 4'($urandom);
    t.y1 = 4'($urandom); t.y2 = 4'($urandom); t.wr = 2'($urandom); t.cc = 1'($urandom);
    t.k = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    t.ld = ($urandom_range(0, 3) == 0); t.ldd = $urandom; t.pcinc = 1'($urandom);
    return t;
  endfunction

  initial begin
    logic [31:0] v;
    instr_t      t;
    int          idx;
    logic [2:0]  co;

    idle();
    sbus.alu_op = 3'b000; sbus.form = 1'b0; sbus.A = 2'd0; sbus.B = 2'd0; sbus.C = 2'd0;
    sbus.D = 2'd0; sbus.Y1 = 2'd0; sbus.Y2 = 2'd0; sbus.write = 2'b00; sbus.const_c = 1'b0;
    sbus.constant = 8'd0; sbus.ld = 1'b0; sbus.ld_data = 8'd0; sbus.pc_inc = 1'b0;
    sbus.compare_op = 3'd0;
    model_reset();

    // Reset state
    #1;
    chk("rst_pc", bus.program_counter, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_div0", bus.div0, 0);
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      chk($sformatf("rst_reg%0d", i), v, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed single-cycle vector table
    vt[0]  = '{mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 2'b01, 1'b1, 32'd5, 1'b0, 32'd0, 1'b0), 4'd1, 32'd5, 4'd0, 32'd0};
    vt[1]  = '{mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 2'b01, 1'b1, 32'd7, 1'b0, 32'd0, 1'b0), 4'd2, 32'd7, 4'd1, 32'd5};
    vt[2]  = '{mk(OP_ADD, 1'b0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 2'b01, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1), 4'd3, 32'd12, 4'd2, 32'd7};
    vt[3]  = '{mk(OP_ADD, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 2'b00, 1'b1, 32'd99, 1'b0, 32'd0, 1'b0), 4'd1, 32'd5, 4'd2, 32'd7};
    vt[4]  = '{mk(OP_SUB, 1'b1, 4'd3, 4'd1, 4'd2, 4'd1, 4'd4, 4'd5, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0), 4'd4, 32'd7, 4'd5, 32'd2};
    vt[5]  = '{mk(OP_SUB, 1'b1, 4'd3, 4'd1, 4'd2, 4'd1, 4'd6, 4'd6, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0), 4'd6, 32'd7, 4'd5, 32'd2};
    vt[6]  = '{mk(OP_XOR, 1'b1, 4'd2, 4'd1, 4'd3, 4'd4, 4'd7, 4'd8, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0), 4'd7, 32'd2, 4'd8, 32'd11};
    vt[7]  = '{mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0, 2'b01, 1'b1, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0), 4'd9, 32'hDEAD_BEEF, 4'd8, 32'd11};
    vt[8]  = '{mk(OP_AND, 1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 2'b10, 1'b1, 32'h0000_F0F0, 1'b0, 32'd0, 1'b0), 4'd10, 32'h0000_B0E0, 4'd9, 32'hDEAD_BEEF};
    vt[9]  = '{mk(OP_OR,  1'b0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd11, 4'd0, 2'b01, 1'b1, 32'h0000_000F, 1'b0, 32'd0, 1'b0), 4'd11, 32'd15, 4'd4, 32'd7};
    vt[10] = '{mk(OP_CPY, 1'b1, 4'd3, 4'd0, 4'd5, 4'd0, 4'd12, 4'd13, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0), 4'd12, 32'd12, 4'd13, 32'd2};
    vt[11] = '{mk(OP_SUB, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd14, 4'd15, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0), 4'd14, 32'hFFFF_FFFB, 4'd15, 32'hFFFF_FFFB};
    for (int i = 0; i < 12; i++) begin
      run(vt[i].in);
      read_reg(vt[i].r1, v);
      chk($sformatf("vec%0d_r%0d", i, vt[i].r1), v, {32'd0, vt[i].e1});
      read_reg(vt[i].r2, v);
      chk($sformatf("vec%0d_r%0d", i, vt[i].r2), v, {32'd0, vt[i].e2});
    end
    chk("pc_after_table", bus.program_counter, 1);

    // MULT 0xFFFFFFFF * 2, PC frozen while busy
    run(mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0));
    run(mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd0, 2'b01, 1'b1, 32'd2, 1'b0, 32'd0, 1'b0));
    run(mk(OP_MUL, 1'b0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd9, 4'd10, 2'b11, 1'b0, 32'd0, 1'b1, 32'h1234_5678, 1'b1));
    read_reg(4'd9, v);  chk("mul_lo", v, 32'hFFFF_FFFE);
    read_reg(4'd10, v); chk("mul_hi", v, 32'd1);
    chk("mul_pc", bus.program_counter, 2);

    // DIV 100/7, 100/0, then a fresh DIV clears div0
    run(mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd11, 4'd0, 2'b01, 1'b1, 32'd100, 1'b0, 32'd0, 1'b0));
    run(mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd12, 4'd0, 2'b01, 1'b1, 32'd7, 1'b0, 32'd0, 1'b0));
    run(mk(OP_DIV, 1'b0, 4'd11, 4'd0, 4'd12, 4'd0, 4'd13, 4'd14, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    read_reg(4'd13, v); chk("div_q", v, 32'd14);
    read_reg(4'd14, v); chk("div_r", v, 32'd2);
    chk("div_div0", bus.div0, 0);
    run(mk(OP_DIV, 1'b0, 4'd11, 4'd0, 4'd0, 4'd0, 4'd13, 4'd14, 2'b11, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0));
    read_reg(4'd13, v); chk("div0_q", v, 32'hFFFF_FFFF);
    read_reg(4'd14, v); chk("div0_r", v, 32'd100);
    chk("div0_flag", bus.div0, 1);
    run(mk(OP_DIV, 1'b0, 4'd11, 4'd0, 4'd12, 4'd0, 4'd13, 4'd0, 2'b01, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    chk("div0_cleared", bus.div0, 0);
    read_reg(4'd13, v); chk("div_q_again", v, 32'd14);

    // MULT with write=00 is a no-op
    run(mk(OP_MUL, 1'b0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd9, 4'd10, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    chk("mul_nowrite_busy", bus.busy, 0);
    read_reg(4'd9, v); chk("mul_nowrite_r9", v, 32'hFFFF_FFFE);

    // Signed vs unsigned compare
    run(mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd0, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0));
    run(mk(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 2'b01, 1'b1, 32'd1, 1'b0, 32'd0, 1'b0));
    cmp_chk("cmp_lt",  3'd4, 4'd15, 4'd1, 1'b1);
    cmp_chk("cmp_ltu", 3'd2, 4'd15, 4'd1, 1'b0);
    cmp_chk("cmp_ge",  3'd5, 4'd15, 4'd1, 1'b0);
    cmp_chk("cmp_geu", 3'd3, 4'd15, 4'd1, 1'b1);
    cmp_chk("cmp_eq",  3'd0, 4'd15, 4'd15, 1'b1);
    cmp_chk("cmp_ne",  3'd1, 4'd15, 4'd15, 1'b0);
    cmp_chk("cmp_f6",  3'd6, 4'd15, 4'd1, 1'b0);
    idle();

    // Reset asserted mid-MULT aborts the write-back
    drive(mk(OP_MUL, 1'b0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd3, 4'd4, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    step();
    idle();
    chk("midrst_busy_before", bus.busy, 1);
    repeat (5) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pc", bus.program_counter, 0);
    chk("midrst_div0", bus.div0, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (40) step();
    chk("midrst_busy_later", bus.busy, 0);
    read_reg(4'd3, v); chk("midrst_r3", v, 32'd0);
    read_reg(4'd4, v); chk("midrst_r4", v, 32'd0);

    // PC wrap on the 8-bit instance
    sbus.pc_inc = 1'b1;
    repeat (255) step();
    chk("pc_max", sbus.program_counter, 8'hFF);
    step();
    chk("pc_wrap", sbus.program_counter, 8'h00);
    sbus.pc_inc = 1'b0;
    step();
    chk("pc_hold", sbus.program_counter, 8'h00);
    chk("main_pc_idle", bus.program_counter, 0);

    // Randomized instructions against the model
    for (int it = 0; it < 250; it++) begin
      t = rnd_instr();
      run(t);
      read_reg(t.y1, v);
      chk("rand_y1", v, {32'd0, m_reg[t.y1]});
      idx = $urandom_range(0, 15);
      read_reg(4'(idx), v);
      chk("rand_reg", v, {32'd0, m_reg[idx]});
      chk("rand_pc", bus.program_counter, {32'd0, m_pc});
      chk("rand_div0", bus.div0, m_div0);
      chk("rand_busy", bus.busy, 0);
      co = 3'($urandom);
      cmp_chk("rand_cond", co, t.a, t.b, m_cond(co, m_reg[t.a], m_reg[t.b]));
      idle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
